// File: rtl/voice_arbiter.sv
// voice_arbiter: picks one piano key (last-pressed priority) plus the current
// octave, and loads {note, octave} into the tone generator with valid/ready.
// Ports: clk, nrst (async, active low), key_in[NKEYS], oct_up_in, oct_dn_in,
//   gen_ready -> note_valid, note_out[NOTE_W], octave_out[3], gate.
// Option: define VARB_SUSTAIN_EN to add sustain_in (hold the note on release).
module voice_arbiter #(
   parameter int         NKEYS   = 13,
   parameter int         NOTE_W  = 4,
   parameter logic [2:0] OCT_RST = 3'd3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [NKEYS-1:0]  key_in,
   input  logic              oct_up_in,
   input  logic              oct_dn_in,
   input  logic              gen_ready,
`ifdef VARB_SUSTAIN_EN
   input  logic              sustain_in,
`endif
   output logic              note_valid,
   output logic [NOTE_W-1:0] note_out,
   output logic [2:0]        octave_out,
   output logic              gate
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] PLAY = 2'd2;

   // Edge-detected inputs: keys, octave up, octave down.
   localparam int NED = NKEYS + 2;
`ifdef VARB_SUSTAIN_EN
   localparam int NIN = NED + 1;
`else
   localparam int NIN = NED;
`endif

   logic [NIN-1:0]    raw;
   logic [NIN-1:0]    s1_q, s2_q;
   logic [NED-1:0]    prev_q, rise;
   logic [NKEYS-1:0]  keys, key_rise;
   logic              up_rise, dn_rise, sus_lvl;

`ifdef VARB_SUSTAIN_EN
   assign raw     = {sustain_in, oct_dn_in, oct_up_in, key_in};
   assign sus_lvl = s2_q[NED];
`else
   assign raw     = {oct_dn_in, oct_up_in, key_in};
   assign sus_lvl = 1'b0;
`endif

   assign rise     = s2_q[NED-1:0] & ~prev_q;
   assign keys     = s2_q[NKEYS-1:0];
   assign key_rise = rise[NKEYS-1:0];
   assign up_rise  = rise[NKEYS];
   assign dn_rise  = rise[NKEYS+1];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
      end else begin
         s1_q   <= raw;
         s2_q   <= s1_q;
         prev_q <= s2_q[NED-1:0];
      end
   end

   // Key selection: a new press wins, else keep the held selection,
   // else fall back to the lowest held key.
   logic              sel_vld_q, sel_vld_d, sel_held;
   logic [NOTE_W-1:0] sel_q, sel_d;

   always_comb begin
      sel_held = 1'b0;
      for (int i = 0; i < NKEYS; i++)
         if (keys[i] && sel_q == NOTE_W'(i)) sel_held = 1'b1;
      sel_vld_d = 1'b0;
      sel_d     = '0;
      if (|key_rise) begin
         sel_vld_d = 1'b1;
         for (int i = NKEYS-1; i >= 0; i--)
            if (key_rise[i]) sel_d = NOTE_W'(i);
      end else if (sel_vld_q && sel_held) begin
         sel_vld_d = 1'b1;
         sel_d     = sel_q;
      end else if (|keys) begin
         sel_vld_d = 1'b1;
         for (int i = NKEYS-1; i >= 0; i--)
            if (keys[i]) sel_d = NOTE_W'(i);
      end
   end

   // Pending octave always tracks every step; octave_out lags it
   // while a load is outstanding.
   logic [2:0] oct_pend_q, oct_pend_d;

   always_comb begin
      oct_pend_d = oct_pend_q;
      if (up_rise && !dn_rise)
         oct_pend_d = (oct_pend_q == 3'd6) ? 3'd0 : oct_pend_q + 3'd1;
      else if (dn_rise && !up_rise)
         oct_pend_d = (oct_pend_q == 3'd0) ? 3'd6 : oct_pend_q - 3'd1;
   end

   logic [1:0]        state_q, state_d;
   logic              valid_q, valid_d, gate_q, gate_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [2:0]        oct_q, oct_d;
   logic              have_note, retune;

   assign have_note = sel_vld_d || sus_lvl;
   assign retune    = have_note &&
                      ((sel_vld_d && sel_d != note_q) ||
                       oct_pend_d != oct_q);

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      note_d  = note_q;
      oct_d   = oct_q;
      gate_d  = gate_q;
      unique case (state_q)
         IDLE: begin
            gate_d  = 1'b0;
            valid_d = 1'b0;
            oct_d   = oct_pend_d;
            if (sel_vld_d) begin
               state_d = LOAD;
               valid_d = 1'b1;
               note_d  = sel_d;
            end
         end
         LOAD: begin
            if (gen_ready) begin
               gate_d = 1'b1;
               oct_d  = oct_pend_d;
               if (sel_vld_d) note_d = sel_d;
               // Re-issue immediately if things moved during the load.
               state_d = retune ? LOAD : PLAY;
               valid_d = retune;
            end else if (!sel_vld_d) begin
               state_d = IDLE;
               valid_d = 1'b0;
               gate_d  = 1'b0;
            end
         end
         PLAY: begin
            gate_d = 1'b1;
            oct_d  = oct_pend_d;
            if (!have_note) begin
               state_d = IDLE;
               gate_d  = 1'b0;
               valid_d = 1'b0;
            end else if (retune) begin
               state_d = LOAD;
               valid_d = 1'b1;
               if (sel_vld_d) note_d = sel_d;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            gate_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         gate_q     <= 1'b0;
         note_q     <= '0;
         oct_q      <= OCT_RST;
         oct_pend_q <= OCT_RST;
         sel_vld_q  <= 1'b0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         gate_q     <= gate_d;
         note_q     <= note_d;
         oct_q      <= oct_d;
         oct_pend_q <= oct_pend_d;
         sel_vld_q  <= sel_vld_d;
         sel_q      <= sel_d;
      end
   end

   assign note_valid = valid_q;
   assign note_out   = note_q;
   assign octave_out = oct_q;
   assign gate       = gate_q;

endmodule

// File: tb/tb_voice_arbiter.sv
// tb_voice_arbiter: scoreboard bench for voice_arbiter.
// Expected loads are queued on stimulus and popped on each handshake.
module tb_voice_arbiter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [12:0] key = '0;
   logic        up = 1'b0;
   logic        dn = 1'b0;
   logic        ready = 1'b1;
   logic        sustain = 1'b0;
   logic        note_valid;
   logic [3:0]  note_out;
   logic [2:0]  octave_out;
   logic        gate;

   voice_arbiter dut (
      .clk        (clk),
      .nrst       (nrst),
      .key_in     (key),
      .oct_up_in  (up),
      .oct_dn_in  (dn),
      .gen_ready  (ready),
`ifdef VARB_SUSTAIN_EN
      .sustain_in (sustain),
`endif
      .note_valid (note_valid),
      .note_out   (note_out),
      .octave_out (octave_out),
      .gate       (gate)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [6:0] sb[$];
   logic [6:0] exp_ld;
   int         exp_oct;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] ld(input int n, input int o);
      return {4'(n), 3'(o)};
   endfunction

   task automatic press_oct(input logic u, input logic d);
      up = u;
      dn = d;
      tick(4);
      up = 1'b0;
      dn = 1'b0;
      tick(4);
   endtask

   // Handshake monitor: an accept happens on the next posedge.
   always @(negedge clk) begin
      if (nrst && note_valid && ready) begin
         if (sb.size() == 0) begin
            check("load_extra", 32'({note_out, octave_out}), 32'hffff);
         end else begin
            exp_ld = sb.pop_front();
            check("load", 32'({note_out, octave_out}), 32'(exp_ld));
         end
      end
   end

   initial begin
      // Reset
      tick(2);
      check("rst_oct", 32'(octave_out), 32'd3);
      check("rst_gate", 32'(gate), 32'd0);
      check("rst_valid", 32'(note_valid), 32'd0);
      check("rst_note", 32'(note_out), 32'd0);
      nrst = 1'b1;
      tick(5);
      check("idle_oct", 32'(octave_out), 32'd3);
      check("idle_valid", 32'(note_valid), 32'd0);

      // Single key, ready high
      key[4] = 1'b1;
      sb.push_back(ld(4, 3));
      tick(3);
      check("t2_valid", 32'(note_valid), 32'd1);
      check("t2_note", 32'(note_out), 32'd4);
      check("t2_oct", 32'(octave_out), 32'd3);
      check("t2_gate0", 32'(gate), 32'd0);
      tick(1);
      check("t2_pulse", 32'(note_valid), 32'd0);
      check("t2_gate1", 32'(gate), 32'd1);
      key[4] = 1'b0;
      tick(2);
      check("t2_gate_hold", 32'(gate), 32'd1);
      tick(1);
      check("t2_gate_off", 32'(gate), 32'd0);

      // Priority and fallback
      key[2] = 1'b1;
      sb.push_back(ld(2, 3));
      tick(6);
      check("t3_gate", 32'(gate), 32'd1);
      key[9] = 1'b1;
      sb.push_back(ld(9, 3));
      tick(3);
      check("t3_legato", 32'(gate), 32'd1);
      check("t3_n9", 32'(note_out), 32'd9);
      tick(3);
      key[9] = 1'b0;
      sb.push_back(ld(2, 3));
      tick(3);
      check("t3_back2", 32'(note_out), 32'd2);
      check("t3_gate2", 32'(gate), 32'd1);
      tick(3);
      key[5] = 1'b1;
      key[7] = 1'b1;
      sb.push_back(ld(5, 3));
      tick(3);
      check("t3_n5", 32'(note_out), 32'd5);
      tick(3);
      key = '0;
      tick(4);
      check("t3_off", 32'(gate), 32'd0);

      // Octave stepping while playing
      key[0] = 1'b1;
      sb.push_back(ld(0, 3));
      tick(6);
      exp_oct = 3;
      for (int i = 0; i < 4; i++) begin
         exp_oct = (exp_oct + 1) % 7;
         sb.push_back(ld(0, exp_oct));
         press_oct(1'b1, 1'b0);
         check("t4_up", 32'(octave_out), 32'(exp_oct));
      end
      sb.push_back(ld(0, 6));
      press_oct(1'b0, 1'b1);
      check("t4_dn", 32'(octave_out), 32'd6);
      press_oct(1'b1, 1'b1);
      check("t4_both", 32'(octave_out), 32'd6);
      check("t4_sb", 32'(sb.size()), 32'd0);
      key = '0;
      tick(5);
      check("t4_off", 32'(gate), 32'd0);

      // Stalled load with octave steps pending
      ready = 1'b0;
      key[3] = 1'b1;
      sb.push_back(ld(3, 6));
      sb.push_back(ld(3, 1));
      tick(3);
      check("t5_valid", 32'(note_valid), 32'd1);
      press_oct(1'b1, 1'b0);
      press_oct(1'b1, 1'b0);
      check("t5_hold_v", 32'(note_valid), 32'd1);
      check("t5_hold_n", 32'(note_out), 32'd3);
      check("t5_hold_o", 32'(octave_out), 32'd6);
      check("t5_gate0", 32'(gate), 32'd0);
      ready = 1'b1;
      tick(1);
      check("t5_reissue", 32'(note_valid), 32'd1);
      check("t5_oct2", 32'(octave_out), 32'd1);
      check("t5_gate1", 32'(gate), 32'd1);
      tick(1);
      check("t5_play", 32'(note_valid), 32'd0);
      check("t5_sb", 32'(sb.size()), 32'd0);

      // Reset while playing
      nrst = 1'b0;
      #1;
      check("rp_gate", 32'(gate), 32'd0);
      check("rp_oct", 32'(octave_out), 32'd3);
      check("rp_note", 32'(note_out), 32'd0);
      key = '0;
      tick(2);
      nrst = 1'b1;
      tick(5);
      check("rp_idle", 32'(gate), 32'd0);

      // Reset while loading
      ready = 1'b0;
      key[6] = 1'b1;
      tick(3);
      check("rl_valid", 32'(note_valid), 32'd1);
      check("rl_note", 32'(note_out), 32'd6);
      nrst = 1'b0;
      #1;
      check("rl_drop", 32'(note_valid), 32'd0);
      key = '0;
      tick(1);
      nrst = 1'b1;
      ready = 1'b1;
      tick(5);
      check("rl_idle_v", 32'(note_valid), 32'd0);
      check("rl_idle_g", 32'(gate), 32'd0);

`ifdef VARB_SUSTAIN_EN
      sustain = 1'b1;
      tick(4);
      key[0] = 1'b1;
      sb.push_back(ld(0, 3));
      tick(6);
      check("t6_gate", 32'(gate), 32'd1);
      key = '0;
      tick(6);
      check("t6_sus_g", 32'(gate), 32'd1);
      check("t6_sus_n", 32'(note_out), 32'd0);
      sustain = 1'b0;
      tick(4);
      check("t6_off", 32'(gate), 32'd0);
`endif

      for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
